// File: rtl/traffic_signal_monitor.sv
// Conflict monitor between the intersection controller and the lamp drivers.
// Registers light codes, decodes lamps, and latches the first safety fault.
module traffic_signal_monitor #(
  parameter int STARTUP_CYC = 2,
  parameter int YELLOW_MAX  = 8,
  parameter int FLASH_HALF  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ns_light,
  input  logic [1:0] ew_light,
  input  logic       fault_clear,
  output logic [2:0] lamp_ns,
  output logic [2:0] lamp_ew,
  output logic       fault,
  output logic [2:0] fault_code
);

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_MONITOR,
    ST_FAULT
  } state_t;

  localparam logic [7:0] SU_LAST = 8'(STARTUP_CYC - 1);
  localparam logic [7:0] FL_LAST = 8'(2 * FLASH_HALF - 1);
  localparam logic [7:0] FL_HALF = 8'(FLASH_HALF);
  localparam logic [7:0] Y_MAX   = 8'(YELLOW_MAX);
  localparam logic [2:0] RED     = 3'b100;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_s_ns, r_s_ew, r_p_ns, r_p_ew;
  logic [7:0] r_dw_ns, r_dw_ew, w_dw_ns, w_dw_ew;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_fcnt, w_fcnt_nxt, w_fcnt_inc;
  logic [2:0] r_lamp_ns, r_lamp_ew, w_lns_nxt, w_lew_nxt;
  logic       r_fault, w_fault_nxt;
  logic [2:0] r_code, w_code_nxt, w_viol;

  function automatic logic [2:0] f_dec(input logic [1:0] c);
    unique case (c)
      2'b00:   return 3'b100;
      2'b01:   return 3'b010;
      2'b10:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic f_bad(input logic [1:0] p, input logic [1:0] s);
    return (p == 2'b00 && s == 2'b01) || (p == 2'b01 && s == 2'b10);
  endfunction

  always_comb begin
    w_dw_ns = 8'd1;
    w_dw_ew = 8'd1;
    if (r_s_ns == r_p_ns)
      w_dw_ns = (r_dw_ns == 8'hFF) ? 8'hFF : r_dw_ns + 8'd1;
    if (r_s_ew == r_p_ew)
      w_dw_ew = (r_dw_ew == 8'hFF) ? 8'hFF : r_dw_ew + 8'd1;
  end

  // Lowest code number wins when several checks fire together.
  always_comb begin
    w_viol = 3'd0;
    if (r_s_ns == 2'b11 || r_s_ew == 2'b11)
      w_viol = 3'd1;
    else if (r_s_ns != 2'b00 && r_s_ew != 2'b00)
      w_viol = 3'd2;
    else if (f_bad(r_p_ns, r_s_ns) || f_bad(r_p_ew, r_s_ew))
      w_viol = 3'd3;
    else if ((r_s_ns == 2'b01 && w_dw_ns > Y_MAX) ||
             (r_s_ew == 2'b01 && w_dw_ew > Y_MAX))
      w_viol = 3'd4;
  end

  assign w_fcnt_inc = (r_fcnt == FL_LAST) ? 8'd0 : r_fcnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fcnt_nxt  = r_fcnt;
    w_lns_nxt   = r_lamp_ns;
    w_lew_nxt   = r_lamp_ew;
    w_fault_nxt = r_fault;
    w_code_nxt  = r_code;
    unique case (r_state)
      ST_STARTUP: begin
        w_lns_nxt = RED;
        w_lew_nxt = RED;
        if (r_cnt == SU_LAST) begin
          w_state_nxt = ST_MONITOR;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_MONITOR: begin
        if (w_viol != 3'd0) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = 1'b1;
          w_code_nxt  = w_viol;
          w_fcnt_nxt  = 8'd0;
          w_lns_nxt   = RED;
          w_lew_nxt   = RED;
        end else begin
          w_lns_nxt = f_dec(r_s_ns);
          w_lew_nxt = f_dec(r_s_ew);
        end
      end
      ST_FAULT: begin
        if (fault_clear) begin
          w_state_nxt = ST_STARTUP;
          w_cnt_nxt   = 8'd0;
          w_fault_nxt = 1'b0;
          w_code_nxt  = 3'd0;
          w_lns_nxt   = RED;
          w_lew_nxt   = RED;
        end else begin
          w_fcnt_nxt = w_fcnt_inc;
          w_lns_nxt  = (w_fcnt_inc < FL_HALF) ? RED : 3'b000;
          w_lew_nxt  = (w_fcnt_inc < FL_HALF) ? RED : 3'b000;
        end
      end
      default: w_state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STARTUP;
      r_s_ns    <= 2'b00;
      r_s_ew    <= 2'b00;
      r_p_ns    <= 2'b00;
      r_p_ew    <= 2'b00;
      r_dw_ns   <= 8'd0;
      r_dw_ew   <= 8'd0;
      r_cnt     <= 8'd0;
      r_fcnt    <= 8'd0;
      r_lamp_ns <= RED;
      r_lamp_ew <= RED;
      r_fault   <= 1'b0;
      r_code    <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ns    <= ns_light;
      r_s_ew    <= ew_light;
      r_p_ns    <= r_s_ns;
      r_p_ew    <= r_s_ew;
      r_dw_ns   <= w_dw_ns;
      r_dw_ew   <= w_dw_ew;
      r_cnt     <= w_cnt_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_lamp_ns <= w_lns_nxt;
      r_lamp_ew <= w_lew_nxt;
      r_fault   <= w_fault_nxt;
      r_code    <= w_code_nxt;
    end
  end

  assign lamp_ns    = r_lamp_ns;
  assign lamp_ew    = r_lamp_ew;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule
